lcd_pixel_scanner: RTL and testbench
====================================

Name: lcd_pixel_scanner

Overview:
- Raster-scans the LCD frame and drives the pixel address bus (xAddLCD/yAddLCD) shared by the text pixel generators.
- Waits out the font ROM read latency, samples the returned textPixEN, and selects the text or background colour.
- Presents one colour word per pixel to the LCD write path over a valid/ready handshake.
- Sits directly upstream of the text generator (address source) and downstream of it (consumer of textPixEN).

Parameters:
WIDTH, 240, pixels per line (x range 0..WIDTH-1)
HEIGHT, 320, lines per frame (y range 0..HEIGHT-1)
BITS_WIDTH, 8, width of x address
BITS_HEIGHT, 9, width of y address
TEXT_LATENCY, 1, clock cycles from address change to valid textPixEN (font ROM registered read); legal 1..7
COLOUR_BITS, 16, width of colour words

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins one frame scan when idle
busy  output  1  high from accepted start until frameDone cycle inclusive
xAddLCD  output  BITS_WIDTH  current pixel x address to text generators
yAddLCD  output  BITS_HEIGHT  current pixel y address to text generators
textPixEN  input  1  text pixel enable returned for current address, valid TEXT_LATENCY cycles after address change
textColour  input  COLOUR_BITS  colour used when textPixEN=1
backColour  input  COLOUR_BITS  colour used when textPixEN=0
pixelData  output  COLOUR_BITS  colour word to LCD writer
pixelValid  output  1  pixelData valid
pixelReady  input  1  LCD writer accepts pixelData when high with pixelValid
frameDone  output  1  one-cycle pulse after last pixel of frame accepted

Behaviour:
- Reset (async, immediate): state IDLE; xAddLCD=0, yAddLCD=0, pixelData=0, pixelValid=0, busy=0, frameDone=0, wait counter=0, last-issued flag=0.
- States: IDLE, SCAN, FLUSH.
- IDLE: addresses held at 0. start=1 -> SCAN, busy=1, wait counter=0. start ignored in every other state.
- Wait counter: increments each cycle in SCAN while < TEXT_LATENCY, saturating at TEXT_LATENCY.
- Capture: in SCAN when wait counter==TEXT_LATENCY and output register free (pixelValid=0, or pixelValid=1 and pixelReady=1 this cycle).
  - At the capture edge: pixelData <= textPixEN ? textColour : backColour (colours sampled at that edge), pixelValid <= 1, wait counter <= 0.
  - Address advances in raster order: x+1; at x=WIDTH-1, x=0 and y+1.
  - Capture of pixel (WIDTH-1, HEIGHT-1): addresses return to (0,0) and state -> FLUSH; no further capture.
- Address registers change only at a capture edge, so they stay stable while the output stalls. The ROM output therefore stays valid, and no sample is lost or duplicated.
- Handshake:
  - pixelValid stays 1 and pixelData stays stable until pixelReady=1. Transfer occurs on a cycle with both high.
  - pixelValid <= 0 after transfer unless a capture happens on the same edge (back-to-back).
  - pixelReady while pixelValid=0 has no effect.
- Throughput: 1 pixel per TEXT_LATENCY+1 cycles with pixelReady held high. A frame is WIDTH*HEIGHT transfers, each pixel exactly once.
- FLUSH: waits for final transfer. On that edge pixelValid <= 0, frameDone <= 1 for one cycle, state -> IDLE. busy falls on the cycle after frameDone.
- A start pulse coincident with frameDone is ignored. A new frame requires start in IDLE.
- Widths: counters compare against WIDTH-1/HEIGHT-1 at full address width, with no wrap beyond range. A TEXT_LATENCY-sized counter uses 3 bits.

Test Plan:
1. Overrides WIDTH=4, HEIGHT=3, TEXT_LATENCY=1; pixelReady=1; textPixEN model true at (x=1,y=2) only, textColour=16'hFFFF, backColour=16'h0000; pulse start -> 12 transfers, 2 cycles apart. Only the 10th (x=1,y=2) is FFFF. frameDone pulses once, 1 cycle after the 12th transfer, then busy=0.
2. Same setup, pixelReady low for 5 cycles at pixel 3 -> pixelData/pixelValid held and addresses frozen at (3,0). After release, pixel order is unbroken and the total is still 12.
3. TEXT_LATENCY=3, bench delays textPixEN 3 cycles via register chain -> transfers 4 cycles apart; the colour for each pixel matches the delayed model with no off-by-one.
4. Assert reset for 1 cycle mid-frame at pixel 7 with pixelValid=1 -> pixelValid, busy, and addresses go to 0 immediately without waiting for a clock edge; no frameDone. A later start scans the full 12 pixels from (0,0).
5. Pulse start while busy, and again on the frameDone cycle -> ignored, with exactly one frame of 12 pixels. A start pulse 2 cycles later begins a second frame.
6. Default parameters, pixelReady=1 -> 76800 transfers. The last address is (239,319), and frameDone occurs after cycle 153600 from start.

Source files
------------

// File: rtl/lcd_pixel_scanner_if.sv
// Pixel address / colour bus between the frame scanner, the text generators and the LCD writer.
interface lcd_pixel_scanner_if #(
  parameter int BITS_WIDTH  = 8,
  parameter int BITS_HEIGHT = 9,
  parameter int COLOUR_BITS = 16
);
  logic [BITS_WIDTH-1:0]  xAddLCD;
  logic [BITS_HEIGHT-1:0] yAddLCD;
  logic                   textPixEN;
  logic [COLOUR_BITS-1:0] textColour;
  logic [COLOUR_BITS-1:0] backColour;
  logic [COLOUR_BITS-1:0] pixelData;
  logic                   pixelValid;
  logic                   pixelReady;

  modport master (
    output xAddLCD, yAddLCD, pixelData, pixelValid,
    input  textPixEN, textColour, backColour, pixelReady
  );

  modport slave (
    input  xAddLCD, yAddLCD, pixelData, pixelValid,
    output textPixEN, textColour, backColour, pixelReady
  );
endinterface

// File: rtl/lcd_pixel_scanner.sv
// Raster-scans one LCD frame, waits out the font ROM latency per pixel and streams
// text/background colour words to the LCD writer over valid/ready.
module lcd_pixel_scanner #(
  parameter int WIDTH        = 240,
  parameter int HEIGHT       = 320,
  parameter int BITS_WIDTH   = 8,
  parameter int BITS_HEIGHT  = 9,
  parameter int TEXT_LATENCY = 1,
  parameter int COLOUR_BITS  = 16
)(
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_frameDone,
  lcd_pixel_scanner_if.master bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_FLUSH = 2'd2} state_t;

  localparam logic [2:0]             LAT    = 3'(TEXT_LATENCY);
  localparam logic [BITS_WIDTH-1:0]  X_LAST = BITS_WIDTH'(WIDTH - 1);
  localparam logic [BITS_HEIGHT-1:0] Y_LAST = BITS_HEIGHT'(HEIGHT - 1);

  state_t                 r_state, w_next;
  logic [2:0]             r_wait;
  logic [BITS_WIDTH-1:0]  r_x;
  logic [BITS_HEIGHT-1:0] r_y;
  logic [COLOUR_BITS-1:0] r_data;
  logic                   r_valid, r_busy, r_done, r_last;
  logic                   w_accept, w_free, w_capture, w_last_pix, w_xfer, w_flush_done;

  always_comb begin
    // A start landing on the frameDone cycle sees IDLE but must not relaunch.
    w_accept     = (r_state == S_IDLE) && i_start && !r_done;
    w_free       = !r_valid || bus.pixelReady;
    w_capture    = (r_state == S_SCAN) && (r_wait == LAT) && w_free;
    w_last_pix   = (r_x == X_LAST) && (r_y == Y_LAST);
    w_xfer       = r_valid && bus.pixelReady;
    w_flush_done = (r_state == S_FLUSH) && r_last && w_xfer;
    w_next       = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_SCAN;
      S_SCAN:  if (w_capture && w_last_pix) w_next = S_FLUSH;
      S_FLUSH: if (w_flush_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_flush_done;

      if (w_accept)    r_busy <= 1'b1;
      else if (r_done) r_busy <= 1'b0;

      if (w_accept || w_capture)                  r_wait <= '0;
      else if (r_state == S_SCAN && r_wait < LAT) r_wait <= r_wait + 3'd1;

      if (w_capture) begin
        r_data  <= bus.textPixEN ? bus.textColour : bus.backColour;
        r_valid <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end

      // Addresses move only on capture so the ROM output stays valid across stalls.
      if (w_capture) begin
        if (w_last_pix) begin
          r_x    <= '0;
          r_y    <= '0;
          r_last <= 1'b1;
        end else if (r_x == X_LAST) begin
          r_x <= '0;
          r_y <= r_y + BITS_HEIGHT'(1);
        end else begin
          r_x <= r_x + BITS_WIDTH'(1);
        end
      end else if (w_flush_done) begin
        r_last <= 1'b0;
      end
    end
  end

  assign o_busy         = r_busy;
  assign o_frameDone    = r_done;
  assign bus.xAddLCD    = r_x;
  assign bus.yAddLCD    = r_y;
  assign bus.pixelData  = r_data;
  assign bus.pixelValid = r_valid;
endmodule

// File: tb/tb_lcd_pixel_scanner.sv
// Randomized bench: two small scanner instances (latency 1 and 3) checked against a raster-order
// colour queue built from a per-frame text map, plus handshake, timing and reset checks.
module tb_lcd_pixel_scanner;
  localparam int AW = 4, AH = 3, AL = 1;
  localparam int BW = 5, BH = 4, BL = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic busy_a, busy_b, done_a, done_b;
  int   checks = 0, errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_pixel_scanner_if #(.BITS_WIDTH(3), .BITS_HEIGHT(2), .COLOUR_BITS(16)) if_a();
  lcd_pixel_scanner_if #(.BITS_WIDTH(3), .BITS_HEIGHT(3), .COLOUR_BITS(16)) if_b();

  lcd_pixel_scanner #(.WIDTH(AW), .HEIGHT(AH), .BITS_WIDTH(3), .BITS_HEIGHT(2),
                      .TEXT_LATENCY(AL), .COLOUR_BITS(16)) u_a (
    .i_clock(clk), .i_reset(rst), .i_start(start_a),
    .o_busy(busy_a), .o_frameDone(done_a), .bus(if_a.master));

  lcd_pixel_scanner #(.WIDTH(BW), .HEIGHT(BH), .BITS_WIDTH(3), .BITS_HEIGHT(3),
                      .TEXT_LATENCY(BL), .COLOUR_BITS(16)) u_b (
    .i_clock(clk), .i_reset(rst), .i_start(start_b),
    .o_busy(busy_b), .o_frameDone(done_b), .bus(if_b.master));

  // Text generator models: per-frame bitmap behind a register chain of the ROM latency.
  bit          map_a[AH][AW];
  bit          map_b[BH][BW];
  logic        chain_a = 1'b0;
  logic [BL-1:0] chain_b = '0;
  always @(posedge clk) begin
    chain_a <= map_a[int'(if_a.yAddLCD)][int'(if_a.xAddLCD)];
    chain_b <= {chain_b[BL-2:0], map_b[int'(if_b.yAddLCD)][int'(if_b.xAddLCD)]};
  end
  assign if_a.textPixEN = chain_a;
  assign if_b.textPixEN = chain_b[BL-1];

  logic [15:0] expq_a[$], expq_b[$];
  int          xf[2], dn[2], lastx[2], stc[2];
  bit          full[2], hold[2];
  logic [15:0] hd[2];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic new_frame(input int sel, input bit fixed, input bit gapchk);
    logic [15:0] tc, bc;
    tc = fixed ? 16'hFFFF : 16'($urandom);
    bc = fixed ? 16'h0000 : 16'($urandom);
    if (sel == 0) begin
      if_a.textColour = tc; if_a.backColour = bc; if_a.pixelReady = 1'b1;
      expq_a.delete();
      for (int y = 0; y < AH; y++)
        for (int x = 0; x < AW; x++) begin
          map_a[y][x] = fixed ? (x == 1 && y == 2) : 1'($urandom);
          expq_a.push_back(map_a[y][x] ? tc : bc);
        end
    end else begin
      if_b.textColour = tc; if_b.backColour = bc; if_b.pixelReady = 1'b1;
      expq_b.delete();
      for (int y = 0; y < BH; y++)
        for (int x = 0; x < BW; x++) begin
          map_b[y][x] = 1'($urandom);
          expq_b.push_back(map_b[y][x] ? tc : bc);
        end
    end
    xf[sel] = 0; dn[sel] = 0; full[sel] = gapchk;
  endtask

  task automatic pulse_start(input int sel);
    @(posedge clk); #1;
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    stc[sel] = cyc;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    chk($sformatf("busy_on%0d", sel), (sel == 0) ? busy_a : busy_b, 1);
  endtask

  task automatic set_ready(input int sel, input logic r);
    if (sel == 0) if_a.pixelReady = r; else if_b.pixelReady = r;
  endtask

  task automatic wait_done(input int sel, input bit rnd, input bit start_on_done);
    int n = 0;
    while (((sel == 0) ? done_a : done_b) !== 1'b1 && n < 400) begin
      if (rnd) set_ready(sel, $urandom_range(0, 3) != 0);
      @(posedge clk); #1; n++;
    end
    chk($sformatf("done_seen%0d", sel), n < 400, 1);
    chk($sformatf("busy_at_done%0d", sel), (sel == 0) ? busy_a : busy_b, 1);
    if (start_on_done) begin
      if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    end
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    chk($sformatf("busy_after%0d", sel), (sel == 0) ? busy_a : busy_b, 0);
    chk($sformatf("done_pulse%0d", sel), (sel == 0) ? done_a : done_b, 0);
    chk($sformatf("pix_count%0d", sel), xf[sel], (sel == 0) ? AW * AH : BW * BH);
    chk($sformatf("done_count%0d", sel), dn[sel], 1);
  endtask

  task automatic mon_step(input int sel);
    logic v, r, d, empty;
    logic [15:0] data, e;
    e = '0;
    if (sel == 0) begin v = if_a.pixelValid; r = if_a.pixelReady; data = if_a.pixelData; d = done_a; end
    else          begin v = if_b.pixelValid; r = if_b.pixelReady; data = if_b.pixelData; d = done_b; end
    if (rst) begin hold[sel] = 1'b0; return; end
    if (v && r) begin
      if (sel == 0) begin empty = expq_a.size() == 0; if (!empty) e = expq_a.pop_front(); end
      else          begin empty = expq_b.size() == 0; if (!empty) e = expq_b.pop_front(); end
      if (empty) chk($sformatf("extra_xfer%0d", sel), 1, 0);
      else       chk($sformatf("pixel%0d_%0d", sel, xf[sel]), data, e);
      if (full[sel] && xf[sel] > 0)
        chk($sformatf("xfer_gap%0d", sel), cyc - lastx[sel], (sel == 0) ? AL + 1 : BL + 1);
      xf[sel]++; lastx[sel] = cyc;
    end
    if (hold[sel]) chk($sformatf("stall_hold%0d", sel), {v, data}, {1'b1, hd[sel]});
    hold[sel] = v && !r; hd[sel] = data;
    if (d) begin
      dn[sel]++;
      chk($sformatf("done_lat%0d", sel), cyc - lastx[sel], 1);
      if (full[sel])
        chk($sformatf("frame_cycles%0d", sel), cyc - stc[sel],
            (sel == 0) ? (AL + 1) * AW * AH + 2 : (BL + 1) * BW * BH + 2);
    end
  endtask

  initial forever begin
    @(negedge clk);
    mon_step(0);
    mon_step(1);
  end

  initial begin
    int n;
    if_a.pixelReady = 1'b1; if_b.pixelReady = 1'b1;
    if_a.textColour = '0; if_a.backColour = '0;
    if_b.textColour = '0; if_b.backColour = '0;
    #2 rst = 1'b1;
    #2;
    chk("rst_busy", {busy_a, busy_b}, 0);
    chk("rst_done", {done_a, done_b}, 0);
    chk("rst_valid", {if_a.pixelValid, if_b.pixelValid}, 0);
    chk("rst_addr", {if_a.xAddLCD, if_a.yAddLCD, if_b.xAddLCD, if_b.yAddLCD}, 0);
    chk("rst_data", {if_a.pixelData, if_b.pixelData}, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Fixed text map, ready always high: single FFFF pixel at (1,2), exact cadence.
    new_frame(0, 1'b1, 1'b1); pulse_start(0); wait_done(0, 1'b0, 1'b0);

    // Stall while the third pixel is presented: data held, addresses frozen at (3,0).
    new_frame(0, 1'b1, 1'b0); pulse_start(0);
    n = 0;
    while (xf[0] != 2 && n < 100) begin @(posedge clk); #1; n++; end
    chk("stall_reach", n < 100, 1);
    if_a.pixelReady = 1'b0;
    @(posedge clk); #1;
    repeat (5) begin
      chk("stall_addr", {if_a.xAddLCD, if_a.yAddLCD, if_a.pixelValid}, {3'd3, 2'd0, 1'b1});
      @(posedge clk); #1;
    end
    if_a.pixelReady = 1'b1;
    wait_done(0, 1'b0, 1'b0);

    // Random maps/colours, random backpressure on the latency-1 instance.
    for (int i = 0; i < 4; i++) begin
      new_frame(0, 1'b0, 1'b0); pulse_start(0); wait_done(0, 1'b1, 1'b0);
    end

    // Latency-3 instance: one full-rate frame, then randomized backpressure.
    new_frame(1, 1'b0, 1'b1); pulse_start(1); wait_done(1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      new_frame(1, 1'b0, 1'b0); pulse_start(1); wait_done(1, 1'b1, 1'b0);
    end

    // One-cycle async reset while pixel 7 is presented.
    new_frame(0, 1'b1, 1'b1); pulse_start(0);
    n = 0;
    while (!(xf[0] == 6 && if_a.pixelValid) && n < 100) begin @(posedge clk); #1; n++; end
    chk("rst_reach", n < 100, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_outs", {if_a.pixelValid, busy_a, if_a.xAddLCD, if_a.yAddLCD}, 0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_rst_nodone", dn[0], 0);
    chk("mid_rst_idle", {busy_a, if_a.pixelValid}, 0);
    new_frame(0, 1'b0, 1'b1); pulse_start(0); wait_done(0, 1'b0, 1'b0);

    // Starts while busy and on the frameDone cycle are ignored.
    new_frame(0, 1'b0, 1'b1); pulse_start(0);
    repeat (6) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    wait_done(0, 1'b0, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    chk("ignored_start", {busy_a, if_a.pixelValid}, 0);
    chk("ignored_count", xf[0], AW * AH);
    new_frame(0, 1'b0, 1'b1); pulse_start(0); wait_done(0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
